// File: rtl/l2_arbiter_pkg.sv
// Shared definitions for the L2 port arbiter: FSM state encodings, owner
// identifiers, access direction constants and the round-robin chooser.
package l2_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_IC   = 2'd1,
      ARB_DC   = 2'd2,
      ARB_DONE = 2'd3
   } arb_state_e;

   typedef enum logic {
      OWNER_IC = 1'b0,
      OWNER_DC = 1'b1
   } owner_e;

   localparam logic READ  = 1'b0;
   localparam logic WRITE = 1'b1;

   // Two-input round-robin: a lone requester wins outright; on a tie the
   // requester that did not win last time is chosen.
   function automatic owner_e rr_pick(input logic   ic_req,
                                      input logic   dc_req,
                                      input owner_e last_gnt);
      owner_e pick;
      pick = OWNER_IC;
      if (ic_req && dc_req) begin
         pick = (last_gnt == OWNER_IC) ? OWNER_DC : OWNER_IC;
      end else if (dc_req) begin
         pick = OWNER_DC;
      end
      return pick;
   endfunction

endpackage

// File: rtl/l2_arbiter.sv
// Shares the single L2 cache port between the icache and dcache controllers.
// One access at a time: grant round-robin in IDLE, hold the latched request
// on the L2 port until l2_rdy, then pulse the owner's rdy for one cycle
// together with the registered read line.
module l2_arbiter
   import l2_arbiter_pkg::*;
#(
   parameter int ADDR_W = 28,
   parameter int LINE_W = 128
) (
   input  logic              clk,
   input  logic              reset,
   // icache controller
   input  logic              ic_req,
   input  logic [ADDR_W-1:0] ic_addr,
   input  logic              ic_rw,
   input  logic [LINE_W-1:0] ic_wd,
   output logic              ic_busy,
   output logic              ic_rdy,
   // dcache controller
   input  logic              dc_req,
   input  logic [ADDR_W-1:0] dc_addr,
   input  logic              dc_rw,
   input  logic [LINE_W-1:0] dc_wd,
   output logic              dc_busy,
   output logic              dc_rdy,
   // returned line, valid with ic_rdy / dc_rdy
   output logic [LINE_W-1:0] rd_line,
   // L2 cache port
   output logic              l2_req,
   output logic [ADDR_W-1:0] l2_addr,
   output logic              l2_cache_rw,
   output logic [LINE_W-1:0] l2_wd,
   input  logic              l2_busy,
   input  logic              l2_rdy,
   input  logic [LINE_W-1:0] l2_rd
);

   arb_state_e        state_q;
   owner_e            last_gnt_q;
   logic              l2_req_q;
   logic              ic_rdy_q;
   logic              dc_rdy_q;
   logic [ADDR_W-1:0] addr_q;
   logic              rw_q;
   logic [LINE_W-1:0] wd_q;
   logic [LINE_W-1:0] rd_line_q;

   logic              gnt_vld_d;
   owner_e            gnt_owner_d;

   // Grant decision for this cycle; only meaningful while IDLE and the L2 is free.
   always_comb begin
      gnt_vld_d   = (state_q == ARB_IDLE) && !l2_busy && (ic_req || dc_req);
      gnt_owner_d = rr_pick(ic_req, dc_req, last_gnt_q);
   end

   // A requester is busy whenever the port is taken, the L2 is stalling, or
   // the other side is being granted on this very edge.
   always_comb begin
      ic_busy = (state_q != ARB_IDLE) || l2_busy ||
                (gnt_vld_d && (gnt_owner_d == OWNER_DC));
      dc_busy = (state_q != ARB_IDLE) || l2_busy ||
                (gnt_vld_d && (gnt_owner_d == OWNER_IC));
   end

   // Arbiter FSM with registered L2 request, completion pulses and read line.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ARB_IDLE;
         last_gnt_q <= OWNER_DC;
         l2_req_q   <= 1'b0;
         ic_rdy_q   <= 1'b0;
         dc_rdy_q   <= 1'b0;
         addr_q     <= '0;
         rw_q       <= READ;
         wd_q       <= '0;
         rd_line_q  <= '0;
      end else begin
         case (state_q)
            ARB_IDLE: begin
               ic_rdy_q <= 1'b0;
               dc_rdy_q <= 1'b0;
               if (gnt_vld_d) begin
                  l2_req_q <= 1'b1;
                  if (gnt_owner_d == OWNER_IC) begin
                     state_q <= ARB_IC;
                     addr_q  <= ic_addr;
                     rw_q    <= ic_rw;
                     wd_q    <= ic_wd;
                  end else begin
                     state_q <= ARB_DC;
                     addr_q  <= dc_addr;
                     rw_q    <= dc_rw;
                     wd_q    <= dc_wd;
                  end
               end
            end
            ARB_IC, ARB_DC: begin
               // l2_busy is deliberately not looked at once the access is under way.
               if (l2_rdy) begin
                  state_q    <= ARB_DONE;
                  l2_req_q   <= 1'b0;
                  rd_line_q  <= l2_rd;
                  last_gnt_q <= (state_q == ARB_IC) ? OWNER_IC : OWNER_DC;
                  ic_rdy_q   <= (state_q == ARB_IC);
                  dc_rdy_q   <= (state_q == ARB_DC);
               end
            end
            ARB_DONE: begin
               // The owner drops its request during this cycle, so IDLE sees fresh requests only.
               state_q  <= ARB_IDLE;
               ic_rdy_q <= 1'b0;
               dc_rdy_q <= 1'b0;
            end
            default: begin
               state_q  <= ARB_IDLE;
               l2_req_q <= 1'b0;
               ic_rdy_q <= 1'b0;
               dc_rdy_q <= 1'b0;
            end
         endcase
      end
   end

   assign l2_req      = l2_req_q;
   assign l2_addr     = addr_q;
   assign l2_cache_rw = rw_q;
   assign l2_wd       = wd_q;
   assign ic_rdy      = ic_rdy_q;
   assign dc_rdy      = dc_rdy_q;
   assign rd_line     = rd_line_q;

endmodule

// File: tb/tb_l2_arbiter.sv
// Directed bench for the L2 port arbiter.
module tb_l2_arbiter;

   localparam int AW = 28;
   localparam int LW = 128;

   localparam logic [AW-1:0] IC_A  = 28'h0000123;
   localparam logic [AW-1:0] DC_A  = 28'h0ABC450;
   localparam logic [LW-1:0] RD1   = 128'hDEAD0000_11112222_33334444_0000BEEF;
   localparam logic [LW-1:0] RD2   = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
   localparam logic [LW-1:0] RD3   = 128'h00000001_00000002_00000003_00000004;
   localparam logic [LW-1:0] WD    = 128'h01234567_89ABCDEF_01234567_89ABCDEF;
   localparam logic [LW-1:0] WDALT = 128'hFFFF0000_FFFF0000_FFFF0000_FFFF0000;

   logic          clk = 1'b0;
   logic          reset;
   logic          ic_req, ic_rw, ic_busy, ic_rdy;
   logic [AW-1:0] ic_addr;
   logic [LW-1:0] ic_wd;
   logic          dc_req, dc_rw, dc_busy, dc_rdy;
   logic [AW-1:0] dc_addr;
   logic [LW-1:0] dc_wd;
   logic [LW-1:0] rd_line;
   logic          l2_req, l2_cache_rw, l2_busy, l2_rdy;
   logic [AW-1:0] l2_addr;
   logic [LW-1:0] l2_wd, l2_rd;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   l2_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
      .clk(clk), .reset(reset),
      .ic_req(ic_req), .ic_addr(ic_addr), .ic_rw(ic_rw), .ic_wd(ic_wd),
      .ic_busy(ic_busy), .ic_rdy(ic_rdy),
      .dc_req(dc_req), .dc_addr(dc_addr), .dc_rw(dc_rw), .dc_wd(dc_wd),
      .dc_busy(dc_busy), .dc_rdy(dc_rdy),
      .rd_line(rd_line),
      .l2_req(l2_req), .l2_addr(l2_addr), .l2_cache_rw(l2_cache_rw), .l2_wd(l2_wd),
      .l2_busy(l2_busy), .l2_rdy(l2_rdy), .l2_rd(l2_rd)
   );

   task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset   = 1'b1;
      ic_req  = 1'b0; ic_addr = IC_A; ic_rw = 1'b0; ic_wd = '0;
      dc_req  = 1'b0; dc_addr = DC_A; dc_rw = 1'b0; dc_wd = '0;
      l2_busy = 1'b0; l2_rdy = 1'b0; l2_rd = '0;
      step();
      step();
      reset = 1'b0;
   endtask

   // Wait (bounded) for the L2 request, confirm who owns it, let the L2 take
   // 'lat' extra cycles, complete, and check the one-cycle rdy pulse.
   task automatic do_access(input string tag, input logic exp_ic, input logic [LW-1:0] rdval,
                            input int lat, input logic reraise);
      int n;
      n = 0;
      #1;
      while (!l2_req && n < 20) begin
         step();
         #1;
         n++;
      end
      chk({tag, "_l2req"}, l2_req, 1'b1);
      chk({tag, "_owner_addr"}, l2_addr, exp_ic ? IC_A : DC_A);
      for (int i = 0; i < lat; i++) begin
         step();
         chk({tag, "_hold_req"}, l2_req, 1'b1);
         chk({tag, "_no_rdy"}, {ic_rdy, dc_rdy}, 2'b00);
      end
      l2_rdy = 1'b1;
      l2_rd  = rdval;
      step();
      l2_rdy = 1'b0;
      l2_rd  = '0;
      #1;
      chk({tag, "_ic_rdy"}, ic_rdy, exp_ic);
      chk({tag, "_dc_rdy"}, dc_rdy, !exp_ic);
      chk({tag, "_rd_line"}, rd_line, rdval);
      chk({tag, "_req_drop"}, l2_req, 1'b0);
      if (exp_ic) ic_req = 1'b0;
      else        dc_req = 1'b0;
      step();
      chk({tag, "_rdy_once"}, {ic_rdy, dc_rdy}, 2'b00);
      if (reraise) begin
         if (exp_ic) ic_req = 1'b1;
         else        dc_req = 1'b1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state
      apply_reset();
      #1;
      chk("rst_l2_req", l2_req, 1'b0);
      chk("rst_rdy", {ic_rdy, dc_rdy}, 2'b00);
      chk("rst_rd_line", rd_line, '0);
      chk("rst_busy", {ic_busy, dc_busy}, 2'b00);
      chk("rst_l2_addr", l2_addr, '0);

      // Single icache read
      ic_req = 1'b1; ic_addr = IC_A; ic_rw = 1'b0;
      #1;
      chk("t1_ic_busy_gnt", ic_busy, 1'b0);
      chk("t1_dc_busy_gnt", dc_busy, 1'b1);
      step();
      chk("t1_l2req_next", l2_req, 1'b1);
      chk("t1_l2addr", l2_addr, IC_A);
      chk("t1_rw", l2_cache_rw, 1'b0);
      chk("t1_ic_busy_acc", ic_busy, 1'b1);
      do_access("t1", 1'b1, RD1, 3, 1'b0);

      // Simultaneous requests from reset: IC, DC, IC
      apply_reset();
      ic_req = 1'b1; dc_req = 1'b1;
      do_access("t2a", 1'b1, RD1, 1, 1'b1);
      do_access("t2b", 1'b0, RD2, 0, 1'b1);
      do_access("t2c", 1'b1, RD3, 2, 1'b0);
      do_access("t2d", 1'b0, RD1, 0, 1'b0);

      // l2_busy for 5 cycles with dcache pending
      apply_reset();
      l2_busy = 1'b1; dc_req = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("t3_no_l2req", l2_req, 1'b0);
         chk("t3_dc_busy", dc_busy, 1'b1);
         step();
      end
      l2_busy = 1'b0;
      #1;
      chk("t3_dc_busy_free", dc_busy, 1'b0);
      chk("t3_ic_busy_free", ic_busy, 1'b1);
      step();
      chk("t3_l2req_gnt", l2_req, 1'b1);
      do_access("t3", 1'b0, RD2, 1, 1'b0);

      // dcache write: latched data stays put after dc_wd changes
      dc_req = 1'b1; dc_rw = 1'b1; dc_wd = WD;
      step();
      chk("t4_rw", l2_cache_rw, 1'b1);
      chk("t4_wd", l2_wd, WD);
      dc_wd = WDALT; dc_rw = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t4_wd_hold", l2_wd, WD);
         chk("t4_rw_hold", l2_cache_rw, 1'b1);
      end
      do_access("t4", 1'b0, RD3, 0, 1'b0);

      // Reset mid-access: make IC the last winner first, then reset during IC_ACC
      ic_req = 1'b1;
      do_access("t5a", 1'b1, RD1, 0, 1'b0);
      ic_req = 1'b1;
      step();
      chk("t5_in_acc", l2_req, 1'b1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1;
      chk("t5_l2req_drop", l2_req, 1'b0);
      chk("t5_no_ic_rdy", ic_rdy, 1'b0);
      dc_req = 1'b1;
      #1;
      chk("t5_tie_ic_busy", ic_busy, 1'b0);
      chk("t5_tie_dc_busy", dc_busy, 1'b1);
      do_access("t5b", 1'b1, RD2, 0, 1'b0);
      do_access("t5c", 1'b0, RD3, 0, 1'b0);

      // Requester drops its request mid-access
      dc_req = 1'b1;
      step();
      chk("t6_l2req", l2_req, 1'b1);
      dc_req = 1'b0;
      step();
      step();
      chk("t6_still_req", l2_req, 1'b1);
      l2_rdy = 1'b1; l2_rd = RD1;
      step();
      l2_rdy = 1'b0;
      #1;
      chk("t6_dc_rdy", dc_rdy, 1'b1);
      chk("t6_rd_line", rd_line, RD1);
      step();
      chk("t6_rdy_once", dc_rdy, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t6_no_regrant", l2_req, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
